// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM encoding for the UART bus bridge.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_TX_IDLE  = 5;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO; push is ignored when full, pop is ignored when empty,
// both judged on the occupancy before this edge.
module uart_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Memory-mapped UART bridge: TX FIFO feeding the transmitter handshake, RX FIFO draining the receiver.
// Define UART_IRQ_EN to add the CTRL interrupt-enable register and a registered irq output.
module uart_bus_bridge
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear,
  output logic        irq
);

  tx_state_t   r_tx_state;
  tx_state_t   w_tx_state_nxt;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_rx_clear;
  logic        r_overrun;
  logic [1:0]  w_reg;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic [7:0]  w_tx_head;
  logic [7:0]  w_rx_head;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_tx_idle;
  logic [31:0] w_status;
  logic [31:0] w_ctrl;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_reg     = bus_addr[3:2];
  assign w_wr      = bus_req & bus_we;
  assign w_rd      = bus_req & ~bus_we;
  assign w_tx_push = w_wr & (w_reg == REG_DATA);
  assign w_rx_pop  = w_rd & (w_reg == REG_DATA);
  // The receiver keeps ready high one cycle past our clear pulse; masking it avoids a double capture.
  assign w_rx_push = rx_data_ready & ~r_rx_clear;
  assign w_tx_idle = w_tx_empty & (r_tx_state == TX_IDLE) & ~tx_busy;
  assign w_unused  = ^{bus_addr[1:0], bus_wdata[31:8]};

  uart_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(bus_wdata[7:0]),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  uart_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_data(rx_data),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_VALID] = ~w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_OVERRUN]  = r_overrun;
    w_status[ST_TX_IDLE]  = w_tx_idle;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_DATA:   if (!w_rx_empty) w_rdata = {24'b0, w_rx_head};
      REG_STATUS: w_rdata = w_status;
      REG_CTRL:   w_rdata = w_ctrl;
      default:    w_rdata = '0;
    endcase
  end

  // A new start waits for busy low in IDLE, so bytes never overlap on the line.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty && !tx_busy) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (tx_busy)  w_tx_state_nxt = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) w_tx_state_nxt = TX_IDLE;
      default:      w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_rx_clear <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_ack      <= bus_req;
      r_rdata    <= w_rd ? w_rdata : '0;
      r_tx_start <= w_tx_pop;
      if (w_tx_pop) r_tx_data <= w_tx_head;
      r_rx_clear <= w_rx_push;
      // A drop wins over a simultaneous W1C so no overrun event is lost.
      if (w_rx_push && w_rx_full)
        r_overrun <= 1'b1;
      else if (w_wr && (w_reg == REG_STATUS) && bus_wdata[ST_OVERRUN])
        r_overrun <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  logic r_rx_ie;
  logic r_tx_ie;
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_rx_ie <= bus_wdata[CTRL_RX_IE];
        r_tx_ie <= bus_wdata[CTRL_TX_IE];
      end
      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty) | r_overrun;
    end
  end

  assign w_ctrl = {30'b0, r_tx_ie, r_rx_ie};
  assign irq    = r_irq;
`else
  assign w_ctrl = '0;
  assign irq    = 1'b0;
`endif

  assign bus_ack   = r_ack;
  assign bus_rdata = r_rdata;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign rx_clear  = r_rx_clear;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: queue-based model of both FIFOs, a transmitter/receiver model,
// and a per-cycle compare process on the bus outputs.
module tb_uart_bus_bridge;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, tx_start, tx_busy, rx_data_ready, rx_clear, irq;
  logic [7:0]  tx_data, rx_data;

  always #5 clk = ~clk;

  uart_bus_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_clear(rx_clear), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  bit          m_ovr = 1'b0;
  logic [31:0] exp_q[$];
  logic [7:0]  loop_q[$];

  logic       tx_busy_xmit = 1'b0;
  bit         hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] last_tx = '0;
  int         n_starts = 0;
  int         n_clears = 0;

  assign tx_busy = tx_busy_xmit | hold_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    s[0] = (m_txq.size() == TXD);
    s[1] = (m_txq.size() == 0);
    s[2] = (m_rxq.size() != 0);
    s[3] = (m_rxq.size() == RXD);
    s[4] = m_ovr;
    s[5] = (m_txq.size() == 0) && !tx_busy;
    return s;
  endfunction

  function automatic logic [31:0] model_read_data();
    if (m_rxq.size() == 0) return 32'h0;
    return {24'h0, m_rxq.pop_front()};
  endfunction

  // Transmitter model: accepts a start, stays busy for a random number of cycles, loops the byte back.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        check("tx_start_while_busy", {31'b0, tx_busy}, 32'h0);
        if (m_txq.size() == 0) check("tx_unexpected_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_order", {24'h0, tx_data}, {24'h0, m_txq.pop_front()});
        last_tx      = tx_data;
        n_starts++;
        tx_busy_xmit = 1'b1;
        busy_cnt     = $urandom_range(2, 8);
      end else if (tx_busy_xmit) begin
        check("tx_data_stable", {24'h0, tx_data}, {24'h0, last_tx});
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy_xmit = 1'b0;
          loop_q.push_back(last_tx);
        end
      end
    end
  end

  // Compare process: ack one cycle after every request, read data against the expected queue.
  initial begin
    logic s_req, s_we, prev_clear;
    prev_clear = 1'b0;
    forever begin
      @(posedge clk);
      s_req = bus_req;
      s_we  = bus_we;
      #1;
      if (!rst) begin
        check("bus_ack", {31'b0, bus_ack}, {31'b0, s_req});
        if (s_req && !s_we) begin
          if (exp_q.size() == 0) check("rdata_unexpected", bus_rdata, 32'hDEAD_BEEF);
          else check("rdata", bus_rdata, exp_q.pop_front());
        end
`ifndef UART_IRQ_EN
        check("irq_low", {31'b0, irq}, 32'h0);
`endif
        check("rx_clear_width", {31'b0, rx_clear & prev_clear}, 32'h0);
        if (rx_clear) n_clears++;
        prev_clear = rx_clear;
      end
    end
  end

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = {r, 2'($urandom_range(0, 3))}; bus_wdata = d;
    if (r == R_DATA && m_txq.size() < TXD) m_txq.push_back(d[7:0]);
    if (r == R_STATUS && d[4]) m_ovr = 1'b0;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] r, input logic [31:0] exp);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = {r, 2'($urandom_range(0, 3))};
    exp_q.push_back(exp);
    @(negedge clk);
    bus_req = 1'b0;
  endtask

  task automatic rd_data_model();
    logic [31:0] e;
    e = model_read_data();
    bus_read(R_DATA, e);
  endtask

  task automatic rd_data_lit(input logic [31:0] lit);
    logic [31:0] e;
    e = model_read_data();
    bus_read(R_DATA, lit);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_data = b; rx_data_ready = 1'b1;
    if (m_rxq.size() < RXD) m_rxq.push_back(b);
    else m_ovr = 1'b1;
    t = 0;
    while (!rx_clear && t < 10) begin @(negedge clk); t++; end
    check("rx_clear_seen", {31'b0, rx_clear}, 32'h1);
    @(negedge clk);
    rx_data_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic tx_drain();
    int t;
    t = 0;
    while ((m_txq.size() != 0 || tx_busy_xmit) && t < 3000) begin @(negedge clk); t++; end
    check("tx_drain_timeout", {31'b0, (t < 3000)}, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, nw, nr;
    logic [7:0] b;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    rx_data_ready = 1'b0; rx_data = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, bus_ack}, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_tx_start", {31'b0, tx_start}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_clear", {31'b0, rx_clear}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    bus_read(R_STATUS, 32'h0000_0022);
    check("status_model_after_rst", model_status(), 32'h0000_0022);

    // Single byte, then loop it back through the receiver
    loop_q.delete();
    n0 = n_starts;
    bus_write(R_DATA, 32'hFFFF_FF55);
    tx_drain();
    check("single_start_count", n_starts - n0, 1);
    bus_read(R_STATUS, 32'h0000_0022);
    if (loop_q.size() > 0) rx_byte(loop_q.pop_front());
    rd_data_lit(32'h55);

    // Nine back-to-back writes while the transmitter is busy: ninth dropped
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b = 8'(8'h30 + i);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = {R_DATA, 2'b00}; bus_wdata = {24'h0, b};
      if (m_txq.size() < TXD) m_txq.push_back(b);
    end
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    bus_read(R_STATUS, 32'h0000_0001);
    n0 = n_starts;
    hold_busy = 1'b0;
    tx_drain();
    check("burst_start_count", n_starts - n0, 8);

    // One receive event yields one capture and one clear pulse
    c0 = n_clears;
    rx_byte(8'hA1);
    check("rx_clear_pulses", n_clears - c0, 1);
    rd_data_lit(32'hA1);
    rd_data_lit(32'h0);

    // RX overrun and W1C
    for (int i = 0; i < 9; i++) rx_byte(8'(8'h60 + i));
    bus_read(R_STATUS, 32'h0000_003E);
    bus_write(R_STATUS, 32'h0000_0010);
    bus_read(R_STATUS, 32'h0000_002E);
    for (int i = 0; i < 8; i++) rd_data_lit(32'h60 + i);
    bus_read(R_STATUS, 32'h0000_0022);

    // CTRL and reserved register
    bus_write(R_RSVD, 32'hFFFF_FFFF);
    bus_read(R_RSVD, 32'h0);
`ifdef UART_IRQ_EN
    bus_write(R_CTRL, 32'h3);
    bus_read(R_CTRL, 32'h3);
    bus_write(R_CTRL, 32'h1);
    rx_byte(8'h5A);
    repeat (2) @(negedge clk);
    check("irq_rx_set", {31'b0, irq}, 32'h1);
    rd_data_lit(32'h5A);
    repeat (2) @(negedge clk);
    check("irq_rx_clear", {31'b0, irq}, 32'h0);
    bus_write(R_CTRL, 32'h0);
`else
    bus_write(R_CTRL, 32'h3);
    bus_read(R_CTRL, 32'h0);
`endif

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      nw = $urandom_range(1, 10);
      for (int i = 0; i < nw; i++) bus_write(R_DATA, $urandom);
      bus_read(R_STATUS, model_status());
      hold_busy = 1'b0;
      tx_drain();
      nr = $urandom_range(0, 10);
      for (int i = 0; i < nr; i++) rx_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) bus_write(R_STATUS, $urandom);
      bus_read(R_STATUS, model_status());
      nr = $urandom_range(0, 10);
      for (int i = 0; i < nr; i++) rd_data_model();
      bus_read(R_STATUS, model_status());
    end
    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
